// File: rtl/dcache_responder.sv
// Direct-mapped, one-word-per-line, write-through, no-write-allocate data cache
// placed between the MEM stage and a slow backing memory with a req/ack handshake.
module dcache_responder #(
    parameter int LINES = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] Address_i,
    input  logic [31:0] Writedata_i,
    output logic [31:0] Readdata_o,
    output logic        stall_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int IDXW = $clog2(LINES);
    localparam int TAGW = 30 - IDXW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RMISS = 2'd1,
        WTHRU = 2'd2,
        WDONE = 2'd3
    } state_t;

    state_t state;

    logic [LINES-1:0] valid;
    logic [TAGW-1:0]  tags  [LINES];
    logic [31:0]      data  [LINES];

    // Word-aligned address and store data captured when a miss or store starts;
    // they feed the backing-memory port so it stays stable until the ack.
    logic [31:0] lat_addr;
    logic [31:0] lat_data;

    logic [IDXW-1:0] req_idx;
    logic [TAGW-1:0] req_tag;
    logic [IDXW-1:0] lat_idx;
    logic [TAGW-1:0] lat_tag;
    logic            req_hit;
    logic            lat_hit;

    // The byte-offset bits never select anything in a word-only cache.
    logic unused_byte_bits;
    assign unused_byte_bits = &{1'b0, Address_i[1:0]};

    assign req_idx = Address_i[IDXW+1:2];
    assign req_tag = Address_i[31:IDXW+2];
    assign lat_idx = lat_addr[IDXW+1:2];
    assign lat_tag = lat_addr[31:IDXW+2];

    // Lookup of the live request (loads only) and of the latched store address.
    assign req_hit = MemRead_i & valid[req_idx] & (tags[req_idx] == req_tag);
    assign lat_hit = valid[lat_idx] & (tags[lat_idx] == lat_tag);

    // Controller state, request latches and line storage updates.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            valid    <= '0;
            lat_addr <= '0;
            lat_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (MemWrite_i) begin
                        lat_addr <= {Address_i[31:2], 2'b00};
                        lat_data <= Writedata_i;
                        state    <= WTHRU;
                    end else if (MemRead_i && !req_hit) begin
                        lat_addr <= {Address_i[31:2], 2'b00};
                        state    <= RMISS;
                    end
                end
                RMISS: begin
                    if (mem_ack_i) begin
                        valid[lat_idx] <= 1'b1;
                        tags[lat_idx]  <= lat_tag;
                        data[lat_idx]  <= mem_rdata_i;
                        state          <= IDLE;
                    end
                end
                WTHRU: begin
                    if (mem_ack_i) begin
                        if (lat_hit) begin
                            data[lat_idx] <= lat_data;
                        end
                        state <= WDONE;
                    end
                end
                WDONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Pipeline and backing-memory outputs; a read hit must answer in the same cycle.
    always_comb begin
        stall_o     = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        Readdata_o  = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (!rst_i) begin
            mem_addr_o  = lat_addr;
            mem_wdata_o = lat_data;
            case (state)
                IDLE: begin
                    if (MemWrite_i) begin
                        stall_o = 1'b1;
                    end else if (MemRead_i) begin
                        if (req_hit) begin
                            Readdata_o = data[req_idx];
                        end else begin
                            stall_o = 1'b1;
                        end
                    end
                end
                RMISS: begin
                    stall_o   = 1'b1;
                    mem_req_o = 1'b1;
                end
                WTHRU: begin
                    stall_o   = 1'b1;
                    mem_req_o = 1'b1;
                    mem_we_o  = 1'b1;
                end
                default: begin
                    stall_o = 1'b0;
                end
            endcase
        end
    end

endmodule
